// File: rtl/gtxe2_chnl_rx_align_if.sv
// ---------------------------------------------------------------------------
// gtxe2_chnl_rx_align_if
// Bundles the data path of the RX comma aligner: the unaligned word stream
// going in and the aligned word stream plus lock status coming out.
//
// Signals:
//   align_en   enables alignment state/offset updates
//   in_valid   qualifier for in_data
//   in_data    unaligned word, bit 0 received first
//   out_valid  registered copy of in_valid
//   out_data   boundary-aligned word
//   comma_det  a comma was found in the current window
//   aligned    aligner is locked
//   realign    one-cycle pulse when the boundary offset changes
//   offset     current boundary offset
//
// Modports:
//   master  word source / status consumer (drives align_en, in_valid, in_data)
//   slave   the aligner itself
// ---------------------------------------------------------------------------
interface gtxe2_chnl_rx_align_if #(
  parameter int width = 20
);
  localparam int ow = $clog2(width);

  logic             align_en;
  logic             in_valid;
  logic [width-1:0] in_data;
  logic             out_valid;
  logic [width-1:0] out_data;
  logic             comma_det;
  logic             aligned;
  logic             realign;
  logic [ow-1:0]    offset;

  modport master (
    output align_en, in_valid, in_data,
    input  out_valid, out_data, comma_det, aligned, realign, offset
  );

  modport slave (
    input  align_en, in_valid, in_data,
    output out_valid, out_data, comma_det, aligned, realign, offset
  );
endinterface

// File: rtl/gtxe2_chnl_rx_align.sv
// ---------------------------------------------------------------------------
// gtxe2_chnl_rx_align
// Comma alignment controller for the GTXE2 RX channel model, running in the
// deserializer outclk domain. Each valid word is concatenated with the
// previous valid word into a 2*width window; every bit offset of the window
// is compared against the K28.5 comma, the lowest matching offset is taken,
// and a HUNT/CHECK/LOCKED machine decides when to adopt it as the word
// boundary. Aligned words leave one cycle after they arrive, already cut at
// any offset chosen from that same word.
//
// Ports:
//   clk      parallel clock (deserializer outclk)
//   reset_n  asynchronous active-low reset
//   bus      gtxe2_chnl_rx_align_if.slave (align_en, in_valid, in_data in;
//            out_valid, out_data, comma_det, aligned, realign, offset out)
//
// Build option:
//   GTXE2_RX_ALIGN_MCOMMA_EN  when defined, the minus comma (mcomma) is
//                             detected alongside the plus comma (pcomma);
//                             otherwise only pcomma is recognised.
// ---------------------------------------------------------------------------
module gtxe2_chnl_rx_align #(
  parameter int         width    = 20,
  parameter int         lock_cnt = 3,
  parameter int         err_cnt  = 4,
  parameter logic [9:0] pcomma   = 10'b0101111100,
  parameter logic [9:0] mcomma   = 10'b1010000011
) (
  input  logic                       clk,
  input  logic                       reset_n,
  gtxe2_chnl_rx_align_if.slave       bus
);

  localparam int ow = $clog2(width);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [1:0]         state, state_nxt;
  logic [3:0]         cnt, cnt_nxt, cnt_inc;
  logic [ow-1:0]      offset_q, off_nxt;
  logic [width-1:0]   prev;
  logic [2*width-1:0] c;
  logic [2*width-1:0] c_shift;
  logic [width-1:0]   match;
  logic               hit;
  logic [ow-1:0]      hit_k;

  logic               out_valid_q;
  logic [width-1:0]   out_data_q;
  logic               comma_det_q;
  logic               realign_q;

  // Newest word in the upper half so that bit 0 of the window is the oldest
  // received bit; a comma can then be found at any offset 0..width-1.
  assign c = {bus.in_data, prev};

  // One 10-bit comparator per candidate offset.
  for (genvar k = 0; k < width; k++) begin : g_cmp
`ifdef GTXE2_RX_ALIGN_MCOMMA_EN
    assign match[k] = (c[k+9:k] == pcomma) || (c[k+9:k] == mcomma);
`else
    assign match[k] = (c[k+9:k] == pcomma);
`endif
  end

`ifndef GTXE2_RX_ALIGN_MCOMMA_EN
  // mcomma has no comparators in this build; the parameter stays so that
  // instantiations are identical whichever way the aligner is built.
  if (mcomma == pcomma) begin : g_mcomma_same_as_pcomma
  end
`endif

  assign hit = |match;

  // Priority pick of the lowest matching offset: scanning downwards lets the
  // lowest index overwrite any higher one.
  always_comb begin
    hit_k = '0;
    for (int k = width - 1; k >= 0; k--) begin
      if (match[k]) begin
        hit_k = ow'(k);
      end
    end
  end

  assign cnt_inc = (cnt == 4'd15) ? cnt : cnt + 4'd1;

  // Alignment state machine; only a valid word with align_en high and a comma
  // somewhere in the window can move it, otherwise everything holds.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    off_nxt   = offset_q;
    if (bus.in_valid && bus.align_en && hit) begin
      case (state)
        HUNT: begin
          off_nxt = hit_k;
          if (lock_cnt == 1) begin
            state_nxt = LOCKED;
            cnt_nxt   = '0;
          end else begin
            state_nxt = CHECK;
            cnt_nxt   = 4'd1;
          end
        end
        CHECK: begin
          if (hit_k == offset_q) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == 4'(lock_cnt)) begin
              state_nxt = LOCKED;
              cnt_nxt   = '0;
            end
          end else begin
            // A comma at a different boundary restarts the confirmation run.
            off_nxt = hit_k;
            cnt_nxt = 4'd1;
          end
        end
        LOCKED: begin
          if (hit_k == offset_q) begin
            cnt_nxt = '0;
          end else begin
            // Misaligned commas accumulate; losing lock keeps the old offset
            // so data keeps flowing on the last known boundary while hunting.
            cnt_nxt = cnt_inc;
            if (cnt_inc == 4'(err_cnt)) begin
              state_nxt = HUNT;
              cnt_nxt   = '0;
            end
          end
        end
        default: begin
          state_nxt = HUNT;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Cutting with off_nxt rather than the stored offset gives the zero-extra-
  // latency behaviour: a word that moves the boundary is itself emitted on
  // the new boundary.
  assign c_shift = c >> off_nxt;

  // Registered outputs and alignment state. Invalid words only clear
  // out_valid; the emitted word, flags and history are held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= HUNT;
      cnt         <= '0;
      offset_q    <= '0;
      prev        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      comma_det_q <= 1'b0;
      realign_q   <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      offset_q    <= off_nxt;
      if (bus.in_valid) begin
        prev        <= bus.in_data;
        out_data_q  <= c_shift[width-1:0];
        comma_det_q <= hit;
        realign_q   <= (off_nxt != offset_q);
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.comma_det = comma_det_q;
  assign bus.aligned   = (state == LOCKED);
  assign bus.realign   = realign_q;
  assign bus.offset    = offset_q;

endmodule
